// File: rtl/alu_iterative.sv
`default_nettype none
// ============================================================================
//  Module   : alu_iterative
//  Purpose  : Registered ALU with start/busy/done handshake. Logic, add/sub,
//             compare and shift opcodes finish on the accepting edge; unsigned
//             multiply (shift-add) and divide (restoring) take WIDTH cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_iterative #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       control_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             op_err
);

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULHU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_REMU  = 4'b1011;
  localparam logic [3:0] OP_SRA   = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;     // multiply: {partial high, remaining multiplier}
  logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand (MUL) or divisor (DIV)
  logic [WIDTH:0]     rem_q, rem_d;       // divide partial remainder
  logic [WIDTH-1:0]   quo_q, quo_d;       // dividend bits shifting out, quotient bits in
  logic               sel_q, sel_d;       // opcode bit 0: high half / remainder
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   sc_result;
  logic               sc_err;
  logic [SH_W-1:0]    shamt;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH:0]     div_rem_next;
  logic [WIDTH-1:0]   div_quo_next;
  logic               last_step;
  logic               is_mul;
  logic               is_div;

  assign busy       = busy_q;
  assign done       = done_q;
  assign alu_result = result_q;
  assign zero       = zero_q;
  assign op_err     = err_q;

  // Single-cycle opcode results, computed straight from the live inputs
  always_comb begin
    sc_result = '0;
    sc_err    = 1'b0;
    shamt     = b[SH_W-1:0];
    case (control_in)
      OP_AND:   sc_result = a & b;
      OP_OR:    sc_result = a | b;
      OP_XOR:   sc_result = a ^ b;
      OP_ADD:   sc_result = a + b;
      OP_SUB:   sc_result = a - b;
      OP_SLT:   sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:   sc_result = a << shamt;
      OP_SRL:   sc_result = a >> shamt;
      OP_SRA:   sc_result = $unsigned($signed(a) >>> shamt);
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: sc_result = '0;
      default:  sc_err = 1'b1;
    endcase
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    mul_sum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    mul_next     = {mul_sum, prod_q[WIDTH-1:1]};
    div_shift    = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    div_ge       = (div_shift >= {1'b0, opnd_q});
    div_rem_next = div_ge ? (div_shift - {1'b0, opnd_q}) : div_shift;
    div_quo_next = {quo_q[WIDTH-2:0], div_ge};
    last_step    = (cnt_q == LAST_CNT);
    is_mul       = (control_in == OP_MUL) || (control_in == OP_MULHU);
    is_div       = (control_in == OP_DIVU) || (control_in == OP_REMU);
  end

  // Next-state logic: acceptance in IDLE, one iteration per cycle otherwise
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    opnd_d   = opnd_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_mul || is_div) begin
            // Operands are captured here; the inputs are not looked at again
            state_d = is_mul ? S_MUL : S_DIV;
            busy_d  = 1'b1;
            cnt_d   = '0;
            sel_d   = control_in[0];
            prod_d  = {{WIDTH{1'b0}}, b};
            opnd_d  = is_mul ? a : b;
            rem_d   = '0;
            quo_d   = a;
          end else begin
            done_d   = 1'b1;
            result_d = sc_result;
            err_d    = sc_err;
          end
        end
      end
      S_MUL: begin
        prod_d = mul_next;
        cnt_d  = cnt_q + 1'b1;
        if (last_step) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b0;
          result_d = sel_q ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
        end
      end
      S_DIV: begin
        rem_d = div_rem_next;
        quo_d = div_quo_next;
        cnt_d = cnt_q + 1'b1;
        if (last_step) begin
          // b=0 naturally yields all-ones quotient and remainder equal to a
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b0;
          result_d = sel_q ? div_rem_next[WIDTH-1:0] : div_quo_next;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // zero only changes alongside a new result
    if (done_d) begin
      zero_d = (result_d == '0);
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      opnd_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      sel_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      opnd_q   <= opnd_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_iterative.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_iterative
//  Purpose  : Directed self-checking bench for alu_iterative (WIDTH=32).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_iterative;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [3:0]       control_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] alu_result;
  logic             zero;
  logic             op_err;

  int checks   = 0;
  int failures = 0;

  alu_iterative #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .control_in (control_in),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .alu_result (alu_result),
    .zero       (zero),
    .op_err     (op_err)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic single(input string tag, input logic [3:0] op, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] exp, input logic exp_zero,
                        input logic exp_err);
    start = 1'b1; control_in = op; a = va; b = vb;
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_res"}, alu_result, exp);
    chk({tag, "_zero"}, zero, exp_zero);
    chk({tag, "_err"}, op_err, exp_err);
  endtask

  // Launch an iterative op, optionally poking an ADD with new operands on cycle 5
  task automatic iter(input string tag, input logic [3:0] op, input logic [31:0] va,
                      input logic [31:0] vb, input logic [31:0] exp, input bit inject);
    int k;
    int busy_cycles;
    start = 1'b1; control_in = op; a = va; b = vb;
    tick();
    start = 1'b0;
    chk({tag, "_busy_e0"}, busy, 1);
    chk({tag, "_done_e0"}, done, 0);
    busy_cycles = busy ? 1 : 0;
    k = 0;
    while (!done && k < 40) begin
      if (inject && k == 4) begin
        start = 1'b1; control_in = 4'b0010; a = 32'd1; b = 32'd2;
      end else begin
        start = 1'b0;
      end
      tick();
      k++;
      if (busy) busy_cycles++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, k, 32);
    chk({tag, "_busy_cycles"}, busy_cycles, 32);
    chk({tag, "_res"}, alu_result, exp);
    chk({tag, "_zero"}, zero, (exp == 0) ? 1 : 0);
    chk({tag, "_err"}, op_err, 0);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int dones;
    reset = 1'b1; start = 1'b0; control_in = 4'b0; a = '0; b = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", alu_result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_err", op_err, 0);

    // Back-to-back single-cycle operations
    single("add", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0);
    single("sub", 4'b0110, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0);
    single("slt", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'h1, 1'b0, 1'b0);
    single("sra", 4'b1101, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b0, 1'b0);
    single("sll", 4'b0100, 32'h0000_0003, 32'h24, 32'h0000_0030, 1'b0, 1'b0);
    single("xor", 4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0);
    start = 1'b0;
    tick();
    chk("idle_done", done, 0);
    chk("idle_hold", alu_result, 32'h0FF0_0FF0);

    // Iterative multiply / divide
    iter("mul",   4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    iter("mulhu", 4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    iter("divu",  4'b1010, 32'd100, 32'd7, 32'd14, 1'b0);
    iter("remu",  4'b1011, 32'd100, 32'd7, 32'd2, 1'b0);
    iter("div0",  4'b1010, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b0);
    iter("rem0",  4'b1011, 32'h1234, 32'd0, 32'h1234, 1'b0);
    iter("busyprot", 4'b1010, 32'd100, 32'd7, 32'd14, 1'b1);

    // Reset in the middle of a multiply
    start = 1'b1; control_in = 4'b1000; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_res", alu_result, 0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dones++;
    end
    chk("mrst_no_done", dones, 0);
    single("add_after_rst", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);

    // Undefined opcode, then a legal op clears op_err
    single("illegal", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b1, 1'b1);
    single("and_clr", 4'b0000, 32'h0000_00FF, 32'h0000_000F, 32'h0000_000F, 1'b0, 1'b0);
    start = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_iterative.md
Name: alu_iterative

Overview:
- Parametrised, registered successor to the datapath ALU.
- Adds wider operand support, an extended opcode set and iterative unsigned multiply/divide.
- Uses a start/busy/done handshake.
- Sits in the execute stage of the multi-cycle core. The control FSM stalls on busy.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 8..64.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  operation request; sampled only when busy=0.
- control_in  input  4  opcode.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- busy  output  1  iterative operation in progress.
- done  output  1  one-cycle pulse: alu_result/zero/op_err valid.
- alu_result  output  WIDTH  registered result.
- zero  output  1  high when alu_result == 0.
- op_err  output  1  high with done when control_in was undefined.

Behaviour:
- Reset (reset=1 at a clk edge): busy=0, done=0, alu_result=0, zero=0, op_err=0, FSM state=IDLE, counter=0. Reset overrides everything, including an operation in progress; no done is produced for an aborted operation.
- Opcodes, single-cycle class:
  - 0000 AND, 0001 OR, 0011 XOR.
  - 0010 ADD, 0110 SUB (wraps modulo 2^WIDTH).
  - 0111 SLT (signed; result 1 or 0).
  - 0100 SLL, 0101 SRL, 1101 SRA: shift amount = b[clog2(WIDTH)-1:0], upper bits of b ignored.
- Opcodes, iterative class (all unsigned):
  - 1000 MUL: low WIDTH bits of a*b.
  - 1001 MULHU: high WIDTH bits of a*b.
  - 1010 DIVU: quotient.
  - 1011 REMU: remainder.
- Any other opcode: alu_result=0, op_err=1, timing as single-cycle class.
- Acceptance: start=1 and busy=0 at an edge (E0). a, b and control_in are latched at E0; later input changes have no effect.
- Single-cycle class: at E0, alu_result/zero/op_err update and done=1 for exactly one cycle. busy stays 0. Back-to-back starts every cycle are legal.
- FSM states: IDLE, MUL, DIV.
  - IDLE -> MUL on accepted 1000/1001; IDLE -> DIV on accepted 1010/1011.
  - At E0 busy goes 1 and the counter loads 0.
  - One shift-add (MUL) or restoring shift-subtract (DIV) step runs per edge, over edges E1..EWIDTH.
  - At EWIDTH: result written, done=1 for one cycle, busy=0, state returns to IDLE.
  - Latency is WIDTH cycles from acceptance to done. A new start may be accepted on the edge right after done.
- start while busy=1: ignored, with no effect on the operation or the outputs.
- op_err=0 for every defined opcode. zero is recomputed with every result, for every opcode.
- alu_result, zero and op_err hold their values between done pulses.
- MUL uses a 2*WIDTH-bit product register. DIV uses a WIDTH+1-bit partial remainder.
- Divide by zero (b=0): DIVU gives all ones; REMU gives a. Full WIDTH-cycle latency, no error flag.

Test Plan:
- Single-cycle ops, WIDTH=32, start for one cycle each, back-to-back:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, zero=0.
  - SUB 5-5 -> 0, zero=1.
  - SLT 0xFFFFFFFF vs 1 -> 1.
  - SRA 0x80000000 by b=0x21 -> 0xC0000000.
  - Expected: done on every cycle, busy never high.
- Multiply, WIDTH=32, a=0xFFFFFFFF, b=0xFFFFFFFF:
  - MUL -> 0x00000001.
  - MULHU -> 0xFFFFFFFE.
  - Expected: busy high for 32 cycles, done exactly 32 cycles after acceptance.
- Divide: a=100, b=7:
  - DIVU -> 14; REMU -> 2.
  - b=0, a=0x1234: DIVU -> 0xFFFFFFFF, REMU -> 0x1234.
- Busy protection: start DIVU 100/7, then on cycle 5 pulse start with ADD and change a and b.
  - Expected: the ADD is ignored and the result is still 14 at cycle 32.
- Reset mid-operation: assert reset at cycle 10 of a MUL.
  - Expected: next cycle busy=0, done=0, alu_result=0, and no done pulse afterwards.
  - A following ADD 2+3 gives 5 one cycle after acceptance.
- Illegal opcode 1111 -> done pulse, op_err=1, alu_result=0, zero=1. The next legal op clears op_err.
